// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: load/store funct3 values and FSM states.
package mem_pkg;

    localparam logic [2:0] LoadB  = 3'b000;
    localparam logic [2:0] LoadH  = 3'b001;
    localparam logic [2:0] LoadW  = 3'b010;
    localparam logic [2:0] LoadBu = 3'b100;
    localparam logic [2:0] LoadHu = 3'b101;

    localparam logic [1:0] StoreB = 2'b00;
    localparam logic [1:0] StoreH = 2'b01;
    localparam logic [1:0] StoreW = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRsp
    } state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, sign/zero extraction for loads, and misalignment/illegal
// type detection. Purely combinational.
module mem_align
    import mem_pkg::*;
(
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  load_type_i,
    input  logic [1:0]  store_type_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        exc_o
);

    logic        st_exc;
    logic        ld_exc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = 32'h0;
        st_exc  = 1'b0;
        case (store_type_i)
            StoreB: begin
                wstrb_o = 4'b0001 << addr_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            StoreH: begin
                wstrb_o = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
                st_exc  = addr_i[0];
            end
            StoreW: begin
                wstrb_o = 4'b1111;
                wdata_o = store_data_i;
                st_exc  = (addr_i != 2'b00);
            end
            default: st_exc = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = rdata_i[7:0];
        case (addr_i)
            2'b00:   ld_byte = rdata_i[7:0];
            2'b01:   ld_byte = rdata_i[15:8];
            2'b10:   ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = 32'h0;
        ld_exc      = 1'b0;
        case (load_type_i)
            LoadB:  load_data_o = {{24{ld_byte[7]}}, ld_byte};
            LoadBu: load_data_o = {24'h0, ld_byte};
            LoadH: begin
                load_data_o = {{16{ld_half[15]}}, ld_half};
                ld_exc      = addr_i[0];
            end
            LoadHu: begin
                load_data_o = {16'h0, ld_half};
                ld_exc      = addr_i[0];
            end
            LoadW: begin
                load_data_o = rdata_i;
                ld_exc      = (addr_i != 2'b00);
            end
            default: ld_exc = 1'b1;
        endcase
    end

    assign exc_o = (mem_read_i & mem_write_i) | (mem_read_i & ld_exc) | (mem_write_i & st_exc);

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: passes ALU results through, runs one data-bus transaction per load or
// store, and presents a registered writeback record with a single-cycle valid pulse.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] store_data_mem,
    input  logic [4:0]  rd_mem,
    input  logic        wb_reg_file_mem,
    input  logic        memtoreg_mem,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic [2:0]  mem_load_type_mem,
    input  logic [2:0]  mem_store_type_mem,
    output logic        dbus_req_valid,
    input  logic        dbus_req_ready,
    output logic [31:0] dbus_addr,
    output logic        dbus_we,
    output logic [3:0]  dbus_wstrb,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_rsp_valid,
    input  logic [31:0] dbus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_file,
    output logic [31:0] wb_data,
    output logic        mem_exc,
    output logic        stall
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  rd_q, rd_d;
    logic        rf_q, rf_d;
    logic        m2r_q, m2r_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  load_type_q, load_type_d;

    logic        req_valid_q, req_valid_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_rf_q, wb_rf_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        mem_exc_q, mem_exc_d;

    logic [1:0]  al_addr;
    logic [2:0]  al_load_type;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_load_data;
    logic        al_exc;
    logic        unused_store_type_msb;

    assign unused_store_type_msb = mem_store_type_mem[2];

    // In IDLE the aligner checks the incoming slot; afterwards it extracts from captured fields.
    assign al_addr      = (state_q == StIdle) ? alu_result_mem[1:0] : addr_q[1:0];
    assign al_load_type = (state_q == StIdle) ? mem_load_type_mem : load_type_q;

    mem_align u_align (
        .mem_read_i   (mem_read_mem),
        .mem_write_i  (mem_write_mem),
        .addr_i       (al_addr),
        .load_type_i  (al_load_type),
        .store_type_i (mem_store_type_mem[1:0]),
        .store_data_i (store_data_mem),
        .rdata_i      (dbus_rdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load_data),
        .exc_o        (al_exc)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        rf_d        = rf_q;
        m2r_d       = m2r_q;
        is_load_d   = is_load_q;
        load_type_d = load_type_q;
        req_valid_d = req_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;
        wb_valid_d  = 1'b0;
        mem_exc_d   = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_rf_d     = wb_rf_q;
        wb_data_d   = wb_data_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (!mem_read_mem && !mem_write_mem) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_mem;
                        wb_rf_d    = wb_reg_file_mem;
                        wb_data_d  = alu_result_mem;
                    end else if (al_exc) begin
                        wb_valid_d = 1'b1;
                        mem_exc_d  = 1'b1;
                        wb_rd_d    = rd_mem;
                        wb_rf_d    = 1'b0;
                        wb_data_d  = alu_result_mem;
                    end else begin
                        addr_d      = alu_result_mem;
                        rd_d        = rd_mem;
                        rf_d        = wb_reg_file_mem;
                        m2r_d       = memtoreg_mem;
                        is_load_d   = mem_read_mem;
                        load_type_d = mem_load_type_mem;
                        req_valid_d = 1'b1;
                        bus_addr_d  = {alu_result_mem[31:2], 2'b00};
                        bus_we_d    = mem_write_mem;
                        bus_wstrb_d = mem_write_mem ? al_wstrb : 4'b0000;
                        bus_wdata_d = mem_write_mem ? al_wdata : 32'h0;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                if (dbus_req_ready) begin
                    req_valid_d = 1'b0;
                    if (is_load_q) begin
                        state_d = StWaitRsp;
                    end else begin
                        state_d    = StIdle;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_rf_d    = 1'b0;
                        wb_data_d  = addr_q;
                    end
                end
            end
            StWaitRsp: begin
                if (dbus_rsp_valid) begin
                    state_d    = StIdle;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_rf_d    = rf_q;
                    wb_data_d  = m2r_q ? al_load_data : addr_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= 32'h0;
            rd_q        <= 5'd0;
            rf_q        <= 1'b0;
            m2r_q       <= 1'b0;
            is_load_q   <= 1'b0;
            load_type_q <= 3'b000;
            req_valid_q <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_we_q    <= 1'b0;
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= 32'h0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_rf_q     <= 1'b0;
            wb_data_q   <= 32'h0;
            mem_exc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            rf_q        <= rf_d;
            m2r_q       <= m2r_d;
            is_load_q   <= is_load_d;
            load_type_q <= load_type_d;
            req_valid_q <= req_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_rf_q     <= wb_rf_d;
            wb_data_q   <= wb_data_d;
            mem_exc_q   <= mem_exc_d;
        end
    end

    assign in_ready       = (state_q == StIdle);
    assign stall          = in_valid & ~in_ready;
    assign dbus_req_valid = req_valid_q;
    assign dbus_addr      = bus_addr_q;
    assign dbus_we        = bus_we_q;
    assign dbus_wstrb     = bus_wstrb_q;
    assign dbus_wdata     = bus_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_reg_file    = wb_rf_q;
    assign wb_data        = wb_data_q;
    assign mem_exc        = mem_exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops push expected writebacks and bus
// requests; negedge monitors pop and compare whenever the DUT presents them.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result_mem;
    logic [31:0] store_data_mem;
    logic [4:0]  rd_mem;
    logic        wb_reg_file_mem;
    logic        memtoreg_mem;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [2:0]  mem_load_type_mem;
    logic [2:0]  mem_store_type_mem;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_file;
    logic [31:0] wb_data;
    logic        mem_exc;
    logic        stall;

    mem_access_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .alu_result_mem     (alu_result_mem),
        .store_data_mem     (store_data_mem),
        .rd_mem             (rd_mem),
        .wb_reg_file_mem    (wb_reg_file_mem),
        .memtoreg_mem       (memtoreg_mem),
        .mem_read_mem       (mem_read_mem),
        .mem_write_mem      (mem_write_mem),
        .mem_load_type_mem  (mem_load_type_mem),
        .mem_store_type_mem (mem_store_type_mem),
        .dbus_req_valid     (dbus_req_valid),
        .dbus_req_ready     (dbus_req_ready),
        .dbus_addr          (dbus_addr),
        .dbus_we            (dbus_we),
        .dbus_wstrb         (dbus_wstrb),
        .dbus_wdata         (dbus_wdata),
        .dbus_rsp_valid     (dbus_rsp_valid),
        .dbus_rdata         (dbus_rdata),
        .wb_valid           (wb_valid),
        .wb_rd              (wb_rd),
        .wb_reg_file        (wb_reg_file),
        .wb_data            (wb_data),
        .mem_exc            (mem_exc),
        .stall              (stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rf;
        logic [31:0] data;
        logic        exc;
        logic        chk_rd;
        logic        chk_data;
    } wb_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        chk_wr;
    } bus_t;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic void push_wb(input logic [4:0] rd, input logic rf, input logic [31:0] d,
                                    input logic exc, input logic crd, input logic cdata);
        wb_t e;
        e.rd = rd; e.rf = rf; e.data = d; e.exc = exc; e.chk_rd = crd; e.chk_data = cdata;
        wb_q.push_back(e);
    endfunction

    function automatic void push_bus(input logic [31:0] a, input logic we, input logic [3:0] s,
                                     input logic [31:0] d, input logic cwr);
        bus_t e;
        e.addr = a; e.we = we; e.wstrb = s; e.wdata = d; e.chk_wr = cwr;
        bus_q.push_back(e);
    endfunction

    // Writeback monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
                end else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    if (e.chk_rd) chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_reg_file", 32'(wb_reg_file), 32'(e.rf));
                    chk("mem_exc", 32'(mem_exc), 32'(e.exc));
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                end
            end else if (mem_exc) begin
                chk("mem_exc_without_wb", 32'(mem_exc), 32'd0);
            end
        end
    end

    // Bus request monitor
    always @(negedge clk) begin
        if (rst_n && dbus_req_valid && dbus_req_ready) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_bus_req", 32'(dbus_req_valid), 32'd0);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                chk("dbus_addr", dbus_addr, e.addr);
                chk("dbus_we", 32'(dbus_we), 32'(e.we));
                if (e.chk_wr) begin
                    chk("dbus_wstrb", 32'(dbus_wstrb), 32'(e.wstrb));
                    chk("dbus_wdata", dbus_wdata, e.wdata);
                end
            end
        end
    end

    task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rf, input logic m2r, input logic mr,
                         input logic mw, input logic [2:0] lt, input logic [2:0] st,
                         input bit exp_exc, input int rdy_dly, input logic [31:0] rdata,
                         input bit hold);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        alu_result_mem = a; store_data_mem = sd; rd_mem = rd; wb_reg_file_mem = rf;
        memtoreg_mem = m2r; mem_read_mem = mr; mem_write_mem = mw;
        mem_load_type_mem = lt; mem_store_type_mem = st;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (hold) begin
            // Next instruction waits in the slot while the memory op is in flight
            alu_result_mem = 32'h5555; rd_mem = 5'd7; wb_reg_file_mem = 1'b1;
            mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        end else begin
            in_valid = 1'b0;
        end
        if (!(mr || mw) || exp_exc) begin
            chk({nm, "_wb_latency1"}, 32'(wb_valid), 32'd1);
            chk({nm, "_no_bus_req"}, 32'(dbus_req_valid), 32'd0);
        end else begin
            for (int i = 0; i < rdy_dly; i++) begin
                chk({nm, "_req_held"}, 32'(dbus_req_valid), 32'd1);
                if (hold) chk({nm, "_stall_req"}, 32'(stall), 32'd1);
                @(posedge clk); #1;
            end
            chk({nm, "_req_valid"}, 32'(dbus_req_valid), 32'd1);
            dbus_req_ready = 1'b1;
            @(posedge clk); #1;
            dbus_req_ready = 1'b0;
            if (mr) begin
                chk({nm, "_req_dropped"}, 32'(dbus_req_valid), 32'd0);
                if (hold) chk({nm, "_stall_rsp"}, 32'(stall), 32'd1);
                dbus_rsp_valid = 1'b1; dbus_rdata = rdata;
                @(posedge clk); #1;
                dbus_rsp_valid = 1'b0;
            end
            chk({nm, "_wb_valid"}, 32'(wb_valid), 32'd1);
            if (hold) begin
                chk({nm, "_stall_released"}, 32'(stall), 32'd0);
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        if (!hold) chk({nm, "_wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_result_mem = '0; store_data_mem = '0; rd_mem = '0;
        wb_reg_file_mem = 1'b0; memtoreg_mem = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        mem_load_type_mem = '0; mem_store_type_mem = '0; dbus_req_ready = 1'b0;
        dbus_rsp_valid = 1'b0; dbus_rdata = '0;
        #12;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_req_valid", 32'(dbus_req_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU passthrough
        push_wb(5'd5, 1'b1, 32'h1234, 1'b0, 1'b1, 1'b1);
        do_op("alu", 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000,
              1'b0, 0, 32'h0, 1'b0);
        chk("wb_data_hold", wb_data, 32'h1234);

        // Stores
        push_bus(32'h1000, 1'b1, 4'b1000, 32'hABABABAB, 1'b1);
        push_wb(5'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        do_op("sb", 32'h1003, 32'h000000AB, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000,
              1'b0, 0, 32'h0, 1'b0);
        push_bus(32'h1004, 1'b1, 4'b1100, 32'hBEEFBEEF, 1'b1);
        push_wb(5'd4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        do_op("sh", 32'h1006, 32'h1234BEEF, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b001,
              1'b0, 1, 32'h0, 1'b0);
        push_bus(32'h1008, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b1);
        push_wb(5'd6, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        do_op("sw", 32'h1008, 32'hDEADBEEF, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b010,
              1'b0, 2, 32'h0, 1'b0);

        // Loads with stalled slot behind them
        push_bus(32'h2000, 1'b0, 4'b0000, 32'h0, 1'b0);
        push_wb(5'd10, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1, 1'b1);
        push_wb(5'd7, 1'b1, 32'h5555, 1'b0, 1'b1, 1'b1);
        do_op("lb", 32'h2001, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000,
              1'b0, 3, 32'h00008000, 1'b1);
        push_bus(32'h2000, 1'b0, 4'b0000, 32'h0, 1'b0);
        push_wb(5'd11, 1'b1, 32'h00000080, 1'b0, 1'b1, 1'b1);
        push_wb(5'd7, 1'b1, 32'h5555, 1'b0, 1'b1, 1'b1);
        do_op("lbu", 32'h2001, 32'h0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 3'b000,
              1'b0, 3, 32'h00008000, 1'b1);

        // Loads, plain
        push_bus(32'h2000, 1'b0, 4'b0000, 32'h0, 1'b0);
        push_wb(5'd12, 1'b1, 32'hFFFF8001, 1'b0, 1'b1, 1'b1);
        do_op("lh", 32'h2002, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 3'b000,
              1'b0, 0, 32'h80010000, 1'b0);
        push_bus(32'h2000, 1'b0, 4'b0000, 32'h0, 1'b0);
        push_wb(5'd13, 1'b1, 32'h00008001, 1'b0, 1'b1, 1'b1);
        do_op("lhu", 32'h2002, 32'h0, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 3'b000,
              1'b0, 1, 32'h80010000, 1'b0);
        push_bus(32'h2004, 1'b0, 4'b0000, 32'h0, 1'b0);
        push_wb(5'd14, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1);
        do_op("lw", 32'h2004, 32'h0, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 3'b000,
              1'b0, 0, 32'hCAFEF00D, 1'b0);
        push_bus(32'h2004, 1'b0, 4'b0000, 32'h0, 1'b0);
        push_wb(5'd15, 1'b1, 32'h2004, 1'b0, 1'b1, 1'b1);
        do_op("lw_nomem2reg", 32'h2004, 32'h0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 3'b000,
              1'b0, 0, 32'hCAFEF00D, 1'b0);

        // Exceptions
        push_wb(5'd0, 1'b0, 32'h3002, 1'b1, 1'b0, 1'b1);
        do_op("exc_lw", 32'h3002, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 3'b000,
              1'b1, 0, 32'h0, 1'b0);
        push_wb(5'd0, 1'b0, 32'h3001, 1'b1, 1'b0, 1'b1);
        do_op("exc_lh", 32'h3001, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 3'b000,
              1'b1, 0, 32'h0, 1'b0);
        push_wb(5'd0, 1'b0, 32'h1001, 1'b1, 1'b0, 1'b1);
        do_op("exc_sh", 32'h1001, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b001,
              1'b1, 0, 32'h0, 1'b0);
        push_wb(5'd0, 1'b0, 32'h3000, 1'b1, 1'b0, 1'b1);
        do_op("exc_ltype", 32'h3000, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 3'b000,
              1'b1, 0, 32'h0, 1'b0);
        push_wb(5'd0, 1'b0, 32'h3004, 1'b1, 1'b0, 1'b1);
        do_op("exc_stype", 32'h3004, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b011,
              1'b1, 0, 32'h0, 1'b0);
        push_wb(5'd0, 1'b0, 32'h3008, 1'b1, 1'b0, 1'b1);
        do_op("exc_both", 32'h3008, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 3'b010,
              1'b1, 0, 32'h0, 1'b0);

        // Stray response in IDLE must be ignored
        dbus_rsp_valid = 1'b1; dbus_rdata = 32'h12345678;
        @(posedge clk); #1;
        dbus_rsp_valid = 1'b0;
        @(posedge clk); #1;
        chk("stray_rsp_no_wb", 32'(wb_valid), 32'd0);

        // Reset while waiting for a load response
        push_bus(32'h2008, 1'b0, 4'b0000, 32'h0, 1'b0);
        alu_result_mem = 32'h2008; rd_mem = 5'd20; wb_reg_file_mem = 1'b1; memtoreg_mem = 1'b1;
        mem_read_mem = 1'b1; mem_write_mem = 1'b0; mem_load_type_mem = 3'b010;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read_mem = 1'b0;
        dbus_req_ready = 1'b1;
        @(posedge clk); #1;
        dbus_req_ready = 1'b0;
        chk("rst_mid_waiting", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_in_ready", 32'(in_ready), 32'd1);
        chk("rst_async_req_valid", 32'(dbus_req_valid), 32'd0);
        chk("rst_async_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_async_wb_data", wb_data, 32'h0);
        chk("rst_async_dbus_addr", dbus_addr, 32'h0);
        chk("rst_async_dbus_wstrb", 32'(dbus_wstrb), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dbus_rsp_valid = 1'b1; dbus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dbus_rsp_valid = 1'b0;
        chk("post_rst_no_wb", 32'(wb_valid), 32'd0);
        chk("post_rst_no_req", 32'(dbus_req_valid), 32'd0);
        chk("post_rst_idle", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
